del_sweep_fsm: RTL and testbench
================================

Name: del_sweep_fsm

Overview:
Next-generation delete sub-FSM under the top-level controller, active while the parent is in its delete state.
- Supports three modes:
  - KEY: delete the single matched cell.
  - MULTI: delete every cell flagged by the memory match vector.
  - FLUSH: delete every valid cell.
- Issues one one-hot delete command per cycle to the memory block and counts the deletions.
- Reports done or error to the parent through ctrl_types_pkg::sub_cmd_t.

Parameters:
NUM_ENTRIES, 16, number of memory cells (>=2)
CNT_W, $clog2(NUM_ENTRIES+1), width of the deletion counter

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
en  input  1  parent is in its delete state; when low, the FSM state is frozen
enter  input  1  first cycle of the delete state; (re)starts the operation
mode  input  del_mode_e (2)  operation mode; sampled only on enter
hit  input  1  memory reports at least one key match
hit_vec  input  NUM_ENTRIES  match vector from memory (may have several bits set)
valid_vec  input  NUM_ENTRIES  occupancy vector from memory
delete_out  output  1  delete strobe to memory
idx_out  output  NUM_ENTRIES  one-hot target cell; zero when delete_out=0
busy  output  1  operation in progress (state is not IDLE)
del_count  output  CNT_W  cells deleted by the current or most recent operation
cmd  output  sub_cmd_t  done and error pulses to the parent

Behaviour:
- Reset values: state=IDLE, pending=0, mode_q=DEL_MODE_KEY, del_count=0. Outputs delete_out=0, idx_out=0, cmd=0, busy=0.
- State register priority: enter > en > hold.
  - enter: state<=LOOKUP, mode_q<=mode, pending<=0, del_count<=0. This aborts any operation in flight with no done/error pulse.
  - en=1 (without enter): state<=next_state.
  - en=0 and enter=0: state, pending and del_count hold. delete_out, idx_out and cmd are forced to 0.
- IDLE: all outputs 0; the FSM leaves IDLE only on enter.
- LOOKUP: memory evaluates the key combinationally during this cycle. Candidate vector:
  - KEY: lowest set bit of hit_vec, gated by hit.
  - MULTI: hit_vec gated by hit.
  - FLUSH: valid_vec; hit is ignored.
- LOOKUP transitions:
  - Candidate nonzero: pending<=candidate, go to SWEEP.
  - Candidate zero, mode KEY or MULTI: go to ERROR.
  - Candidate zero, mode FLUSH: go to DONE (an empty flush is not an error).
  - Reserved mode encoding 2'b11: go to ERROR.
- SWEEP: each cycle:
  - delete_out=1 and idx_out=lsb(pending) (one-hot).
  - pending<=pending & ~idx_out; del_count<=del_count+1.
  - When the cleared pending becomes 0, go to DONE.
  - N set bits take exactly N SWEEP cycles, in ascending index order.
- DONE: cmd.done=1 for one cycle, then IDLE.
- ERROR: cmd.error=1 for one cycle, then IDLE.
- cmd.done and cmd.error are never asserted in the same cycle.
- del_count holds after DONE or ERROR until the next enter. Its maximum value is NUM_ENTRIES, so it cannot wrap.
- Latency, counted from the enter cycle = cycle 0: LOOKUP at 1, first delete at 2, done at 2+N. A KEY miss gives error at 2.
- busy is high in LOOKUP, SWEEP, DONE and ERROR.
- hit_vec and valid_vec are only sampled in LOOKUP. Changes to either during SWEEP have no effect.
- A bit in hit_vec with hit=0 is treated as no match.
- Default/illegal state: next_state=IDLE, all outputs 0.
- Asynchronous reset asserted mid-SWEEP: delete_out drops immediately, pending and del_count are cleared, and no done pulse is issued.

Decomposition:
- ctrl_types_pkg gains:
  - del_mode_e: KEY=2'b00, MULTI=2'b01, FLUSH=2'b10, 2'b11 reserved.
  - del_sweep_state_e: IDLE, LOOKUP, SWEEP, DONE, ERROR.
- ctrl_types_pkg reuses the existing sub_cmd_t.
- Sub-module onehot_lsb_pick #(W): purely combinational; outputs the lowest set bit of its input as a one-hot vector (zero in, zero out). Instantiated twice: once for the LOOKUP candidate in KEY mode, once for the SWEEP target.

Test Plan:
- KEY hit: mode=KEY, hit=1, hit_vec=16'h0020 in LOOKUP -> cycle 2: delete_out=1, idx_out=16'h0020; cycle 3: cmd.done=1; del_count=1.
- KEY miss: mode=KEY, hit=0 -> cycle 2: cmd.error=1, delete_out never asserted, del_count=0.
- MULTI: hit=1, hit_vec=16'h8101 -> idx_out sequence 0x0001, 0x0100, 0x8000 in cycles 2-4; done at cycle 5; del_count=3.
- FLUSH: valid_vec=16'hFFFF -> 16 consecutive deletes 0x0001..0x8000, done at cycle 18, del_count=16. Second case: valid_vec=0 -> done at cycle 2, error never asserted.
- Freeze and abort:
  - In MULTI 0x000F, drop en after the 2nd delete for 3 cycles -> outputs 0 and del_count=2 held; resume -> deletes 0x0004 then 0x0008.
  - Re-pulse enter mid-SWEEP -> restarts at LOOKUP with del_count=0.
- Async reset mid-FLUSH: rst_n low between clock edges -> delete_out=0 immediately; after release busy=0, del_count=0, no cmd pulse.

Source files
------------

// File: rtl/ctrl_types_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_types_pkg
// Shared types for the top-level controller and its sub-FSMs.
//   sub_cmd_t          : done/error pulses from a sub-FSM to its parent
//   del_mode_e         : delete sub-FSM operation mode (2'b11 reserved)
//   del_sweep_state_e  : delete sub-FSM state encoding
// -----------------------------------------------------------------------------
package ctrl_types_pkg;

    typedef struct packed {
        logic done;
        logic error;
    } sub_cmd_t;

    typedef enum logic [1:0] {
        DEL_MODE_KEY   = 2'b00,
        DEL_MODE_MULTI = 2'b01,
        DEL_MODE_FLUSH = 2'b10,
        DEL_MODE_RSVD  = 2'b11
    } del_mode_e;

    typedef enum logic [2:0] {
        DS_IDLE   = 3'd0,
        DS_LOOKUP = 3'd1,
        DS_SWEEP  = 3'd2,
        DS_DONE   = 3'd3,
        DS_ERROR  = 3'd4
    } del_sweep_state_e;

endpackage

// File: rtl/onehot_lsb_pick.sv
// -----------------------------------------------------------------------------
// onehot_lsb_pick
// Purely combinational: isolates the lowest set bit of vec as a one-hot
// vector. Zero in gives zero out.
//   vec : input  [W-1:0]  arbitrary bit vector
//   lsb : output [W-1:0]  one-hot lowest set bit of vec, or zero
// -----------------------------------------------------------------------------
module onehot_lsb_pick #(
    parameter int W = 16
) (
    input  logic [W-1:0] vec,
    output logic [W-1:0] lsb
);

    // Two's-complement trick: vec & -vec keeps only the lowest set bit.
    assign lsb = vec & (~vec + W'(1));

endmodule

// File: rtl/del_sweep_fsm.sv
// -----------------------------------------------------------------------------
// del_sweep_fsm
// Delete sub-FSM, active while the parent sits in its delete state. Depending
// on the mode it deletes the single matched cell (KEY), every matched cell
// (MULTI) or every valid cell (FLUSH), issuing one one-hot delete per cycle in
// ascending index order, and reports done/error back to the parent.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : parent in delete state; low freezes the FSM
//   enter      : first cycle of the delete state; (re)starts the operation
//   mode       : operation mode, sampled on enter
//   hit        : memory reports at least one key match
//   hit_vec    : match vector from memory
//   valid_vec  : occupancy vector from memory
//   delete_out : delete strobe to memory
//   idx_out    : one-hot target cell, zero when delete_out is low
//   busy       : state is not IDLE
//   del_count  : cells deleted by the current or most recent operation
//   cmd        : done/error pulses to the parent
// -----------------------------------------------------------------------------
module del_sweep_fsm
    import ctrl_types_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   enter,
    input  del_mode_e              mode,
    input  logic                   hit,
    input  logic [NUM_ENTRIES-1:0] hit_vec,
    input  logic [NUM_ENTRIES-1:0] valid_vec,
    output logic                   delete_out,
    output logic [NUM_ENTRIES-1:0] idx_out,
    output logic                   busy,
    output logic [CNT_W-1:0]       del_count,
    output sub_cmd_t               cmd
);

    del_sweep_state_e       state_q, state_d;
    del_mode_e              mode_q;
    logic [NUM_ENTRIES-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic [NUM_ENTRIES-1:0] key_pick;
    logic [NUM_ENTRIES-1:0] target;
    logic [NUM_ENTRIES-1:0] cand;
    logic                   del_raw;
    logic [NUM_ENTRIES-1:0] idx_raw;
    sub_cmd_t               cmd_raw;
    logic                   drive;

    onehot_lsb_pick #(.W(NUM_ENTRIES)) u_key_pick (
        .vec (hit_vec),
        .lsb (key_pick)
    );

    onehot_lsb_pick #(.W(NUM_ENTRIES)) u_sweep_pick (
        .vec (pending_q),
        .lsb (target)
    );

    // Candidate set evaluated during LOOKUP; hit gates the match vector so a
    // stray hit_vec bit without hit counts as no match.
    always_comb begin
        cand = '0;
        unique case (mode_q)
            DEL_MODE_KEY:   cand = hit ? key_pick : '0;
            DEL_MODE_MULTI: cand = hit ? hit_vec  : '0;
            DEL_MODE_FLUSH: cand = valid_vec;
            default:        cand = '0;
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        del_raw   = 1'b0;
        idx_raw   = '0;
        cmd_raw   = '0;
        unique case (state_q)
            DS_IDLE: state_d = DS_IDLE;
            DS_LOOKUP: begin
                if (mode_q == DEL_MODE_RSVD) begin
                    state_d = DS_ERROR;
                end else if (cand != '0) begin
                    pending_d = cand;
                    state_d   = DS_SWEEP;
                end else if (mode_q == DEL_MODE_FLUSH) begin
                    state_d = DS_DONE;   // empty flush is not an error
                end else begin
                    state_d = DS_ERROR;
                end
            end
            DS_SWEEP: begin
                // pending is never zero on entry; the guard keeps a corrupted
                // state from counting phantom deletions.
                if (pending_q != '0) begin
                    del_raw   = 1'b1;
                    idx_raw   = target;
                    pending_d = pending_q & ~target;
                    count_d   = count_q + CNT_W'(1);
                end
                if (pending_d == '0) state_d = DS_DONE;
            end
            DS_DONE: begin
                cmd_raw.done = 1'b1;
                state_d      = DS_IDLE;
            end
            DS_ERROR: begin
                cmd_raw.error = 1'b1;
                state_d       = DS_IDLE;
            end
            default: state_d = DS_IDLE;
        endcase
    end

    // Outputs only act on a cycle the FSM will advance: frozen (en low) or
    // restarting (enter) cycles must not delete or pulse the parent.
    assign drive      = en & ~enter;
    assign delete_out = drive & del_raw;
    assign idx_out    = drive ? idx_raw : '0;
    assign cmd        = drive ? cmd_raw : '0;
    assign busy       = (state_q != DS_IDLE);
    assign del_count  = count_q;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DS_IDLE;
            mode_q    <= DEL_MODE_KEY;
            pending_q <= '0;
            count_q   <= '0;
        end else if (enter) begin
            state_q   <= DS_LOOKUP;
            mode_q    <= mode;
            pending_q <= '0;
            count_q   <= '0;
        end else if (en) begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_del_sweep_fsm.sv
// -----------------------------------------------------------------------------
// tb_del_sweep_fsm
// Directed self-checking bench for del_sweep_fsm. Inputs change on the falling
// edge; outputs are sampled on the falling edge, away from the active edge.
// Cycle numbering follows the enter cycle = cycle 0.
// -----------------------------------------------------------------------------
module tb_del_sweep_fsm;
    import ctrl_types_pkg::*;

    localparam int N  = 16;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          enter;
    del_mode_e     mode;
    logic          hit;
    logic [N-1:0]  hit_vec;
    logic [N-1:0]  valid_vec;
    logic          delete_out;
    logic [N-1:0]  idx_out;
    logic          busy;
    logic [CW-1:0] del_count;
    sub_cmd_t      cmd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    del_sweep_fsm #(.NUM_ENTRIES(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .enter      (enter),
        .mode       (mode),
        .hit        (hit),
        .hit_vec    (hit_vec),
        .valid_vec  (valid_vec),
        .delete_out (delete_out),
        .idx_out    (idx_out),
        .busy       (busy),
        .del_count  (del_count),
        .cmd        (cmd)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Applies enter at a falling edge (cycle 0), checks that nothing is
    // driven during the enter cycle, then advances into LOOKUP (cycle 1).
    task automatic start(input del_mode_e m, input logic h,
                         input logic [N-1:0] hv, input logic [N-1:0] vv);
        enter = 1'b1; en = 1'b1; mode = m;
        hit = h; hit_vec = hv; valid_vec = vv;
        #1;
        check("enter_quiet", {delete_out, cmd.done, cmd.error}, 32'd0);
        @(negedge clk);
        step();
        enter = 1'b0;
        #1;
        check("lookup_busy", {31'd0, busy}, 32'd1);
        check("lookup_nodel", {31'd0, delete_out}, 32'd0);
        @(negedge clk);
    endtask

    // Step from cycle k to k+1 without moving off the falling edge.
    task automatic next();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_del(input string tag, input logic [N-1:0] idx);
        check({tag, "_del"}, {31'd0, delete_out}, 32'd1);
        check({tag, "_idx"}, {16'd0, idx_out}, {16'd0, idx});
        check({tag, "_cmd"}, {30'd0, cmd}, 32'd0);
    endtask

    task automatic expect_done(input string tag, input int cnt);
        check({tag, "_done"}, {31'd0, cmd.done}, 32'd1);
        check({tag, "_noerr"}, {31'd0, cmd.error}, 32'd0);
        check({tag, "_dnodel"}, {31'd0, delete_out}, 32'd0);
        next();
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_cnt"}, {27'd0, del_count}, cnt);
        check({tag, "_cmd0"}, {30'd0, cmd}, 32'd0);
    endtask

    task automatic expect_error(input string tag);
        check({tag, "_err"}, {31'd0, cmd.error}, 32'd1);
        check({tag, "_nodone"}, {31'd0, cmd.done}, 32'd0);
        check({tag, "_enodel"}, {31'd0, delete_out}, 32'd0);
        next();
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_cnt"}, {27'd0, del_count}, 32'd0);
    endtask

    initial begin
        logic [N-1:0] bit_i;
        rst_n = 1'b0; en = 1'b0; enter = 1'b0; mode = DEL_MODE_KEY;
        hit = 1'b0; hit_vec = '0; valid_vec = '0;

        // Reset state
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_del", {31'd0, delete_out}, 32'd0);
        check("rst_idx", {16'd0, idx_out}, 32'd0);
        check("rst_cnt", {27'd0, del_count}, 32'd0);
        check("rst_cmd", {30'd0, cmd}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        step();
        check("idle_stays", {31'd0, busy}, 32'd0);

        // KEY hit: single cell 5
        start(DEL_MODE_KEY, 1'b1, 16'h0020, 16'hFFFF);
        expect_del("key_c2", 16'h0020);
        next();
        expect_done("key", 1);

        // KEY with several matches: only the lowest is deleted
        start(DEL_MODE_KEY, 1'b1, 16'h0030, 16'h0000);
        expect_del("key2_c2", 16'h0010);
        next();
        expect_done("key2", 1);

        // KEY miss: hit low although hit_vec has a bit set
        start(DEL_MODE_KEY, 1'b0, 16'h0020, 16'hFFFF);
        expect_error("keymiss");

        // Reserved mode
        start(DEL_MODE_RSVD, 1'b1, 16'h0001, 16'hFFFF);
        expect_error("rsvd");

        // MULTI 0x8101, hit_vec scrambled during SWEEP must not matter
        start(DEL_MODE_MULTI, 1'b1, 16'h8101, 16'h0000);
        hit_vec = 16'hFFFF;
        expect_del("multi_c2", 16'h0001);
        next();
        expect_del("multi_c3", 16'h0100);
        next();
        expect_del("multi_c4", 16'h8000);
        next();
        expect_done("multi", 3);

        // MULTI with hit low: error
        start(DEL_MODE_MULTI, 1'b0, 16'h8101, 16'h0000);
        expect_error("multimiss");

        // FLUSH all 16 cells, hit ignored, valid_vec cleared mid-sweep
        start(DEL_MODE_FLUSH, 1'b0, 16'h0000, 16'hFFFF);
        valid_vec = 16'h0000;
        for (int i = 0; i < N; i++) begin
            bit_i = '0;
            bit_i[i] = 1'b1;
            check("flush_del", {31'd0, delete_out}, 32'd1);
            check("flush_idx", {16'd0, idx_out}, {16'd0, bit_i});
            check("flush_cnt", {27'd0, del_count}, i);
            next();
        end
        expect_done("flush", 16);

        // FLUSH of an empty memory: done at cycle 2, no error
        start(DEL_MODE_FLUSH, 1'b1, 16'hFFFF, 16'h0000);
        expect_done("flush0", 0);

        // Freeze: MULTI 0x000F, en low for 3 cycles after the 2nd delete
        start(DEL_MODE_MULTI, 1'b1, 16'h000F, 16'h0000);
        expect_del("frz_c2", 16'h0001);
        next();
        expect_del("frz_c3", 16'h0002);
        @(posedge clk);
        #1 en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("frz_del", {31'd0, delete_out}, 32'd0);
            check("frz_idx", {16'd0, idx_out}, 32'd0);
            check("frz_cmd", {30'd0, cmd}, 32'd0);
            check("frz_cnt", {27'd0, del_count}, 32'd2);
            check("frz_busy", {31'd0, busy}, 32'd1);
            @(posedge clk);
        end
        #1 en = 1'b1;
        @(negedge clk);
        expect_del("frz_r1", 16'h0004);
        next();
        expect_del("frz_r2", 16'h0008);
        next();
        expect_done("frz", 4);

        // Abort: re-enter mid-SWEEP of MULTI 0x00FF with a KEY operation
        start(DEL_MODE_MULTI, 1'b1, 16'h00FF, 16'h0000);
        expect_del("abt_c2", 16'h0001);
        next();
        expect_del("abt_c3", 16'h0002);
        next();
        start(DEL_MODE_KEY, 1'b1, 16'h0080, 16'h0000);
        check("abt_cnt0", {27'd0, del_count}, 32'd0);
        expect_del("abt_k", 16'h0080);
        next();
        expect_done("abt", 1);

        // Async reset mid-FLUSH
        start(DEL_MODE_FLUSH, 1'b0, 16'h0000, 16'hFFFF);
        expect_del("ar_c2", 16'h0001);
        next();
        expect_del("ar_c3", 16'h0002);
        #2 rst_n = 1'b0;
        #1;
        check("ar_del", {31'd0, delete_out}, 32'd0);
        check("ar_idx", {16'd0, idx_out}, 32'd0);
        check("ar_busy", {31'd0, busy}, 32'd0);
        check("ar_cnt", {27'd0, del_count}, 32'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next();
            check("ar_post_cmd", {30'd0, cmd}, 32'd0);
            check("ar_post_busy", {31'd0, busy}, 32'd0);
            check("ar_post_del", {31'd0, delete_out}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
